// File: rtl/mips_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
// Optional build macro for the timeout path: MIPS_ARB_TIMEOUT_EN.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY
    } arb_state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_e;

    localparam logic [63:0] ARB_ERR_DATA = '1;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the CPU + memory view.
interface mips_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  if_valid;
    logic                  if_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  d_valid;
    logic                  d_ready;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  arb_err;

    modport slave (
        input  if_valid, if_addr, d_valid, d_we, d_addr, d_wdata,
        input  mem_rvalid, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, arb_err
    );

    modport master (
        output if_valid, if_addr, d_valid, d_we, d_addr, d_wdata,
        output mem_rvalid, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, arb_err
    );

endinterface

// File: rtl/mips_arb_timer.sv
// Busy-cycle counter; expire is high TIMEOUT_CYC cycles after the mem_req cycle.
// Only instantiated when MIPS_ARB_TIMEOUT_EN is defined.
module mips_arb_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = busy && (cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: load/store has priority, fetch wins after a data streak.
// Define MIPS_ARB_TIMEOUT_EN to abort silent memory transactions and flag arb_err.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 16
) (
    input logic               clk,
    input logic               rst,
    mips_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e            state;
    arb_state_e            state_nxt;
    grant_e                gnt;
    logic [SW-1:0]         streak;
    logic                  timeout;
    logic                  if_ready;
    logic                  d_ready;
    logic                  if_rvalid;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        gnt = GNT_IF;
        if (bus.d_valid && (!bus.if_valid || streak < STREAK_MAX)) begin
            gnt = GNT_D;
        end
    end

    // A real completion beats a coincident timeout.
    assign rsp_data = bus.mem_rvalid ? bus.mem_rdata
                                     : ARB_ERR_DATA[DATA_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        unique case (state)
            IDLE: begin
                if_ready = bus.if_valid && (gnt == GNT_IF);
                d_ready  = bus.d_valid && (gnt == GNT_D);
                if (if_ready) begin
                    state_nxt = IF_BUSY;
                end else if (d_ready) begin
                    state_nxt = D_BUSY;
                end
            end
            IF_BUSY: begin
                if (bus.mem_rvalid || timeout) begin
                    if_rvalid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            D_BUSY: begin
                if (bus.mem_rvalid || timeout) begin
                    d_rvalid  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            streak  <= '0;
        end else begin
            req_q <= if_ready || d_ready;
            if (if_ready) begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
                streak  <= '0;
            end else if (d_ready) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                if (!bus.if_valid) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end
        end
    end

`ifdef MIPS_ARB_TIMEOUT_EN
    logic err_q;

    mips_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .busy  (state != IDLE),
        .expire(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout && !bus.mem_rvalid) begin
            err_q <= 1'b1;
        end
    end

    assign bus.arb_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.arb_err = 1'b0;
`endif

    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? rsp_data : '0;
    assign bus.d_rdata   = d_rvalid ? rsp_data : '0;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized bench for mips_mem_arbiter with a transaction-level reference model.
// Timeout scenario runs only when MIPS_ARB_TIMEOUT_EN is defined.
module tb_mips_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mips_mem_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_run = 0;
    int n_fail = 0;

    // model of arbiter + memory: owner 0 = free, 1 = fetch, 2 = data
    int          m_owner, m_streak, m_resp, m_tmr, m_gnt;
    int          fixed_lat, obs_gnt, n_if_rv, n_d_rv, n_if_gnt;
    bit          m_pend, m_we, m_err, silent, spur_en;
    logic [15:0] m_addr, m_wdata, last_if_rdata;
    logic [15:0] mem [int];
    int          gq [$];
    int          exp_order [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(logic [15:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : (a ^ 16'h5A5A);
    endfunction

    task automatic model_clear();
        m_owner  = 0;
        m_streak = 0;
        m_resp   = -1;
        m_tmr    = 0;
        m_pend   = 0;
        m_err    = 0;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic cycle();
        bit          fire, tmo, e_ifr, e_dr, e_ifv, e_dv, chk_rd;
        logic [15:0] rd, e_rd;
        m_gnt = 0;
        chk("arb_err", bus.arb_err, m_err);
        chk("mem_req", bus.mem_req, m_pend);
        if (m_pend) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_we", bus.mem_we, m_we);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            m_resp = silent ? -1 : (fixed_lat > 0 ? fixed_lat : $urandom_range(1, 3));
            m_tmr  = 0;
        end else if (m_owner != 0) begin
            m_tmr++;
            if (m_resp > 0) m_resp--;
        end
        m_pend = 0;
        fire = (m_owner != 0) && (m_resp == 0);
        rd = 16'($urandom);
        if (fire) begin
            m_resp = -1;
            if (m_we) mem[int'(m_addr)] = m_wdata;
            else rd = mem_rd(m_addr);
        end
        bus.mem_rvalid = fire || (m_owner == 0 && spur_en && $urandom_range(0, 7) == 0);
        bus.mem_rdata  = rd;
        tmo = 0;
`ifdef MIPS_ARB_TIMEOUT_EN
        tmo = (m_owner != 0) && !fire && (m_tmr == TMO);
`endif
        #1;
        e_ifr = 0; e_dr = 0; e_ifv = 0; e_dv = 0; chk_rd = 0; e_rd = '0;
        if (m_owner != 0) begin
            if (fire || tmo) begin
                e_rd   = fire ? rd : 16'hFFFF;
                chk_rd = tmo || !m_we;
                if (m_owner == 1) e_ifv = 1;
                else e_dv = 1;
                if (tmo) m_err = 1;
                m_owner = 0;
            end
        end else if (bus.d_valid && (!bus.if_valid || m_streak < MAXS)) begin
            e_dr = 1; m_gnt = 2; m_owner = 2; m_pend = 1;
            m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
            m_streak = bus.if_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (bus.if_valid) begin
            e_ifr = 1; m_gnt = 1; m_owner = 1; m_pend = 1;
            m_we = 0; m_addr = bus.if_addr; m_streak = 0;
        end
        obs_gnt = bus.d_ready ? 2 : (bus.if_ready ? 1 : 0);
        if (bus.if_ready) n_if_gnt++;
        if (bus.if_rvalid) begin
            n_if_rv++;
            last_if_rdata = bus.if_rdata;
        end
        if (bus.d_rvalid) n_d_rv++;
        chk("if_ready", bus.if_ready, e_ifr);
        chk("d_ready", bus.d_ready, e_dr);
        chk("if_rvalid", bus.if_rvalid, e_ifv);
        chk("d_rvalid", bus.d_rvalid, e_dv);
        if (chk_rd && e_ifv) chk("if_rdata", bus.if_rdata, e_rd);
        if (chk_rd && e_dv) chk("d_rdata", bus.d_rdata, e_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.if_valid   = 0;
        bus.d_valid    = 0;
        bus.mem_rvalid = 0;
        rst = 1;
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_arb_err", bus.arb_err, 0);
        chk("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
        chk("rst_ready", {bus.if_ready, bus.d_ready}, 0);
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1;
        bus.mem_rdata  = 16'hDEAD;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("stale_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
        @(posedge clk);
        #1;
        bus.mem_rvalid = 0;
        model_clear();
    endtask

    task automatic drive_rand();
        if (!bus.if_valid || m_gnt == 1) begin
            bus.if_valid = 1'($urandom_range(0, 1));
            bus.if_addr  = 16'($urandom_range(0, 63)) << 1;
        end else if ($urandom_range(0, 15) == 0) begin
            bus.if_valid = 0;
        end
        if (!bus.d_valid || m_gnt == 2) begin
            bus.d_valid = 1'($urandom_range(0, 1));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = 16'($urandom_range(0, 63)) << 1;
            bus.d_wdata = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
            bus.d_valid = 0;
        end
    endtask

    initial begin
        bus.if_valid = 0; bus.if_addr = '0;
        bus.d_valid = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
        silent = 0; spur_en = 0; fixed_lat = 0;
        n_if_rv = 0; n_d_rv = 0; n_if_gnt = 0; last_if_rdata = '0;
        model_clear();
        do_reset();

        // single fetch
        mem[16'h0010] = 16'h1234;
        fixed_lat = 2;
        bus.if_valid = 1; bus.if_addr = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (m_gnt == 1) bus.if_valid = 0;
        end
        chk("t1_if_rv_cnt", n_if_rv, 1);
        chk("t1_if_rdata", last_if_rdata, 16'h1234);

        // single store with fetch idle
        n_if_gnt = 0; n_d_rv = 0;
        bus.d_valid = 1; bus.d_we = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (m_gnt == 2) bus.d_valid = 0;
        end
        chk("t2_if_gnt", n_if_gnt, 0);
        chk("t2_d_rv_cnt", n_d_rv, 1);

        // contested stream: streak limit forces periodic fetch grants
        do_reset();
        fixed_lat = 1;
        gq.delete();
        bus.if_valid = 1; bus.d_valid = 1; bus.d_we = 0;
        for (int i = 0; i < 100 && gq.size() < 10; i++) begin
            cycle();
            if (obs_gnt != 0) gq.push_back(obs_gnt);
            if (m_gnt == 1) bus.if_addr = bus.if_addr + 16'd2;
            if (m_gnt == 2) bus.d_addr = bus.d_addr + 16'd4;
        end
        chk("t3_n_gnt", gq.size(), 10);
        for (int i = 0; i < 10 && i < gq.size(); i++) begin
            chk($sformatf("t3_gnt%0d", i), gq[i], exp_order[i]);
        end
        bus.if_valid = 0; bus.d_valid = 0;
        for (int i = 0; i < 4; i++) cycle();

        // reset while a load is in flight, then a clean fetch
        fixed_lat = 3;
        bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 16'h0022;
        cycle();
        bus.d_valid = 0;
        cycle();
        n_d_rv = 0;
        do_reset();
        chk("t4_d_rv_cnt", n_d_rv, 0);
        n_if_rv = 0;
        bus.if_valid = 1; bus.if_addr = 16'h0030;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (m_gnt == 1) bus.if_valid = 0;
        end
        chk("t4_if_rv_cnt", n_if_rv, 1);

`ifdef MIPS_ARB_TIMEOUT_EN
        // silent memory after a fetch
        silent = 1; n_if_rv = 0;
        bus.if_valid = 1; bus.if_addr = 16'h0050;
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (m_gnt == 1) bus.if_valid = 0;
        end
        chk("t5_if_rv_cnt", n_if_rv, 1);
        chk("t5_arb_err", bus.arb_err, 1);
        silent = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_err_sticky", bus.arb_err, 1);
        do_reset();
`endif

        // randomized traffic, with spurious idle completions
        fixed_lat = 0; spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            drive_rand();
            cycle();
        end
        bus.if_valid = 0; bus.d_valid = 0; spur_en = 0;
        for (int i = 0; i < 6; i++) cycle();
        chk("drain_idle", m_owner, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
